// File: rtl/battleship_engine.sv
// Battleship game core: runtime ship placement, shot resolution, sink sweep, win/lose tracking.
// Placement: reject next cycle or done 2*len+1 cycles after accept; shot result next cycle, sink len+1.
// cfg_ready only in SETUP idle, fire_ready only in PLAY idle; requests are held off while the engine walks cells.
//
// Ports:
//   clk, reset (sync, active-high), restart (pulse, play-side only)
//   cfg_*   : ship placement request/response (id, bow row/col, length, orientation)
//   start   : leave SETUP once every ship is loaded
//   fire_*  : shot request; res_valid/res_code carry the result
//   rd_*    : registered renderer read port (2-bit cell status)
//   turns_left, ships_remaining, game_state : game status
module battleship_engine #(
  parameter int GRID_ROWS = 10,
  parameter int GRID_COLS = 10,
  parameter int NUM_SHIPS = 5,
  parameter int MAX_LEN   = 6,
  parameter int TURNS     = 15,
  localparam int RW = $clog2(GRID_ROWS),
  localparam int CW = $clog2(GRID_COLS),
  localparam int IW = (NUM_SHIPS > 1) ? $clog2(NUM_SHIPS) : 1,
  localparam int LW = $clog2(MAX_LEN + 1),
  localparam int TW = $clog2(TURNS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [IW-1:0] cfg_id,
  input  logic [RW-1:0] cfg_row,
  input  logic [CW-1:0] cfg_col,
  input  logic [LW-1:0] cfg_len,
  input  logic          cfg_vert,
  output logic          cfg_done,
  output logic          cfg_err,
  input  logic          start,
  input  logic          fire_valid,
  output logic          fire_ready,
  input  logic [RW-1:0] fire_row,
  input  logic [CW-1:0] fire_col,
  output logic          res_valid,
  output logic [2:0]    res_code,
  input  logic [RW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [1:0]    rd_status,
  output logic [TW-1:0] turns_left,
  output logic [IW:0]   ships_remaining,
  output logic [1:0]    game_state
);

  localparam int NC = GRID_ROWS * GRID_COLS;
  localparam int XW = (NC > 1) ? $clog2(NC) : 1;

  localparam logic [2:0] RES_MISS    = 3'd0;
  localparam logic [2:0] RES_HIT     = 3'd1;
  localparam logic [2:0] RES_SUNK    = 3'd2;
  localparam logic [2:0] RES_REPEAT  = 3'd3;
  localparam logic [2:0] RES_INVALID = 3'd4;

  localparam logic [1:0] ST_UNKNOWN = 2'b00;
  localparam logic [1:0] ST_MISS    = 2'b01;
  localparam logic [1:0] ST_HIT     = 2'b10;
  localparam logic [1:0] ST_SUNK    = 2'b11;

  typedef enum logic [2:0] {
    SETUP_IDLE,
    CHECK,
    WRITE,
    PLAY_IDLE,
    SINK,
    WIN,
    LOSE
  } state_t;

  state_t state_q, state_d;

  // Board storage: shot status plus which ship (if any) owns each cell.
  logic [1:0]    cell_st  [NC];
  logic          cell_occ [NC];
  logic [IW-1:0] cell_id  [NC];

  // Ship table.
  logic [LW-1:0] ship_len  [NUM_SHIPS];
  logic [RW-1:0] ship_row  [NUM_SHIPS];
  logic [CW-1:0] ship_col  [NUM_SHIPS];
  logic          ship_vert [NUM_SHIPS];
  logic [LW-1:0] ship_hits [NUM_SHIPS];
  logic [NUM_SHIPS-1:0] loaded;

  // Cell walker shared by CHECK, WRITE and SINK: bow, direction, length, current cell.
  logic [IW-1:0] p_id;
  logic [LW-1:0] p_len;
  logic          p_vert;
  logic [RW-1:0] base_row, walk_row;
  logic [CW-1:0] base_col, walk_col;
  logic [LW-1:0] step;

  function automatic logic [XW-1:0] cell_ix(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return XW'(int'(r) * GRID_COLS + int'(c));
  endfunction

  // Placement pre-checks evaluated on the handshake cycle.
  logic id_bad, len_bad, bounds_bad, place_bad;
  int   stern_r, stern_c;

  always_comb begin
    id_bad  = (int'(cfg_id) >= NUM_SHIPS) || loaded[cfg_id];
    len_bad = (cfg_len == '0) || (int'(cfg_len) > MAX_LEN);
    stern_r = int'(cfg_row) + (cfg_vert ? int'(cfg_len) - 1 : 0);
    stern_c = int'(cfg_col) + (cfg_vert ? 0 : int'(cfg_len) - 1);
    // Stern at or beyond the bow for len>=1, so this also covers an off-board bow.
    bounds_bad = (stern_r >= GRID_ROWS) || (stern_c >= GRID_COLS);
    place_bad  = id_bad || len_bad || bounds_bad;
  end

  // Shot decode, evaluated against the live board on the handshake cycle.
  logic [XW-1:0] fire_ix, walk_ix, rd_ix;
  logic          fire_in, rd_in;
  logic [1:0]    shot_st;
  logic          shot_occ;
  logic [IW-1:0] shot_id;
  logic [LW-1:0] shot_hits;
  logic          shot_sinks;
  logic          walk_occ, last_step;
  logic          play_grp, do_restart;

  always_comb begin
    fire_ix    = cell_ix(fire_row, fire_col);
    fire_in    = (int'(fire_row) < GRID_ROWS) && (int'(fire_col) < GRID_COLS);
    shot_st    = cell_st[fire_ix];
    shot_occ   = cell_occ[fire_ix];
    shot_id    = cell_id[fire_ix];
    shot_hits  = ship_hits[shot_id] + LW'(1);
    shot_sinks = (shot_hits == ship_len[shot_id]);
    walk_ix    = cell_ix(walk_row, walk_col);
    walk_occ   = cell_occ[walk_ix];
    last_step  = (step == p_len - LW'(1));
    rd_ix      = cell_ix(rd_row, rd_col);
    rd_in      = (int'(rd_row) < GRID_ROWS) && (int'(rd_col) < GRID_COLS);
    play_grp   = (state_q == PLAY_IDLE) || (state_q == SINK) ||
                 (state_q == WIN) || (state_q == LOSE);
    do_restart = restart && play_grp;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= SETUP_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cfg_ready  = 1'b0;
    fire_ready = 1'b0;
    game_state = 2'd0;
    case (state_q)
      SETUP_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          if (!place_bad) state_d = CHECK;
        end else if (start && (&loaded)) begin
          state_d = PLAY_IDLE;
        end
      end
      CHECK: begin
        if (walk_occ)       state_d = SETUP_IDLE;
        else if (last_step) state_d = WRITE;
      end
      WRITE: begin
        if (last_step) state_d = SETUP_IDLE;
      end
      PLAY_IDLE: begin
        fire_ready = 1'b1;
        game_state = 2'd1;
        if (fire_valid && fire_in && (shot_st == ST_UNKNOWN)) begin
          if (shot_occ) begin
            if (shot_sinks) state_d = SINK;
          end else if (turns_left == TW'(1)) begin
            state_d = LOSE;
          end
        end
      end
      SINK: begin
        game_state = 2'd1;
        if (last_step) state_d = (ships_remaining == (IW+1)'(1)) ? WIN : PLAY_IDLE;
      end
      WIN:     game_state = 2'd2;
      LOSE:    game_state = 2'd3;
      default: state_d = SETUP_IDLE;
    endcase
    if (do_restart) state_d = PLAY_IDLE;
  end

  always_ff @(posedge clk) begin
    cfg_done  <= 1'b0;
    cfg_err   <= 1'b0;
    res_valid <= 1'b0;
    // Reads see the board as it stood before this edge's writes.
    rd_status <= rd_in ? cell_st[rd_ix] : ST_UNKNOWN;

    if (reset) begin
      rd_status       <= ST_UNKNOWN;
      res_code        <= RES_MISS;
      turns_left      <= TW'(TURNS);
      ships_remaining <= (IW+1)'(NUM_SHIPS);
      loaded          <= '0;
      p_id            <= '0;
      p_len           <= '0;
      p_vert          <= 1'b0;
      base_row        <= '0;
      base_col        <= '0;
      walk_row        <= '0;
      walk_col        <= '0;
      step            <= '0;
      for (int i = 0; i < NC; i++) begin
        cell_st[i]  <= ST_UNKNOWN;
        cell_occ[i] <= 1'b0;
        cell_id[i]  <= '0;
      end
      for (int s = 0; s < NUM_SHIPS; s++) begin
        ship_len[s]  <= '0;
        ship_row[s]  <= '0;
        ship_col[s]  <= '0;
        ship_vert[s] <= 1'b0;
        ship_hits[s] <= '0;
      end
    end else if (do_restart) begin
      // Layout survives; only the shot history and counters go.
      turns_left      <= TW'(TURNS);
      ships_remaining <= (IW+1)'(NUM_SHIPS);
      for (int i = 0; i < NC; i++) cell_st[i] <= ST_UNKNOWN;
      for (int s = 0; s < NUM_SHIPS; s++) ship_hits[s] <= '0;
    end else begin
      case (state_q)
        SETUP_IDLE: begin
          if (cfg_valid) begin
            if (place_bad) begin
              cfg_done <= 1'b1;
              cfg_err  <= 1'b1;
            end else begin
              p_id     <= cfg_id;
              p_len    <= cfg_len;
              p_vert   <= cfg_vert;
              base_row <= cfg_row;
              base_col <= cfg_col;
              walk_row <= cfg_row;
              walk_col <= cfg_col;
              step     <= '0;
            end
          end
        end
        CHECK: begin
          if (walk_occ) begin
            cfg_done <= 1'b1;
            cfg_err  <= 1'b1;
          end else if (last_step) begin
            walk_row <= base_row;
            walk_col <= base_col;
            step     <= '0;
          end else begin
            if (p_vert) walk_row <= walk_row + RW'(1);
            else        walk_col <= walk_col + CW'(1);
            step <= step + LW'(1);
          end
        end
        WRITE: begin
          cell_occ[walk_ix] <= 1'b1;
          cell_id[walk_ix]  <= p_id;
          if (last_step) begin
            loaded[p_id]    <= 1'b1;
            ship_len[p_id]  <= p_len;
            ship_row[p_id]  <= base_row;
            ship_col[p_id]  <= base_col;
            ship_vert[p_id] <= p_vert;
            cfg_done        <= 1'b1;
          end else begin
            if (p_vert) walk_row <= walk_row + RW'(1);
            else        walk_col <= walk_col + CW'(1);
            step <= step + LW'(1);
          end
        end
        PLAY_IDLE: begin
          if (fire_valid) begin
            if (!fire_in) begin
              res_valid <= 1'b1;
              res_code  <= RES_INVALID;
            end else if (shot_st != ST_UNKNOWN) begin
              res_valid <= 1'b1;
              res_code  <= RES_REPEAT;
            end else if (!shot_occ) begin
              cell_st[fire_ix] <= ST_MISS;
              turns_left       <= turns_left - TW'(1);
              res_valid        <= 1'b1;
              res_code         <= RES_MISS;
            end else begin
              cell_st[fire_ix]   <= ST_HIT;
              ship_hits[shot_id] <= shot_hits;
              if (shot_sinks) begin
                // Result is withheld until the sweep has repainted the hull.
                p_len    <= ship_len[shot_id];
                p_vert   <= ship_vert[shot_id];
                walk_row <= ship_row[shot_id];
                walk_col <= ship_col[shot_id];
                step     <= '0;
              end else begin
                res_valid <= 1'b1;
                res_code  <= RES_HIT;
              end
            end
          end
        end
        SINK: begin
          cell_st[walk_ix] <= ST_SUNK;
          if (last_step) begin
            ships_remaining <= ships_remaining - (IW+1)'(1);
            res_valid       <= 1'b1;
            res_code        <= RES_SUNK;
          end else begin
            if (p_vert) walk_row <= walk_row + RW'(1);
            else        walk_col <= walk_col + CW'(1);
            step <= step + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_battleship_engine.sv
module tb_battleship_engine;
  localparam int R  = 10;
  localparam int C  = 10;
  localparam int NS = 5;
  localparam int ML = 6;
  localparam int T  = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       restart = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_id = '0;
  logic [3:0] cfg_row = '0;
  logic [3:0] cfg_col = '0;
  logic [2:0] cfg_len = '0;
  logic       cfg_vert = 1'b0;
  logic       cfg_done, cfg_err;
  logic       start = 1'b0;
  logic       fire_valid = 1'b0;
  logic       fire_ready;
  logic [3:0] fire_row = '0;
  logic [3:0] fire_col = '0;
  logic       res_valid;
  logic [2:0] res_code;
  logic [3:0] rd_row = '0;
  logic [3:0] rd_col = '0;
  logic [1:0] rd_status;
  logic [3:0] turns_left;
  logic [3:0] ships_remaining;
  logic [1:0] game_state;

  battleship_engine dut (
    .clk(clk), .reset(reset), .restart(restart),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_id(cfg_id), .cfg_row(cfg_row),
    .cfg_col(cfg_col), .cfg_len(cfg_len), .cfg_vert(cfg_vert), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .start(start), .fire_valid(fire_valid), .fire_ready(fire_ready),
    .fire_row(fire_row), .fire_col(fire_col), .res_valid(res_valid), .res_code(res_code),
    .rd_row(rd_row), .rd_col(rd_col), .rd_status(rd_status), .turns_left(turns_left),
    .ships_remaining(ships_remaining), .game_state(game_state)
  );

  always #5 clk = ~clk;

  // Reference model: the board as the rules describe it.
  bit m_occ [R][C];
  int m_id  [R][C];
  int m_st  [R][C];
  int s_row [NS], s_col [NS], s_len [NS], s_hits [NS];
  bit s_vert [NS], m_loaded [NS];
  int m_turns, m_ships, m_gs;
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear_shots();
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) m_st[r][c] = 0;
    for (int s = 0; s < NS; s++) s_hits[s] = 0;
    m_turns = T; m_ships = NS; m_gs = 1;
  endtask

  task automatic model_reset();
    model_clear_shots();
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin m_occ[r][c] = 0; m_id[r][c] = 0; end
    for (int s = 0; s < NS; s++) m_loaded[s] = 0;
    m_gs = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_cfg_done", cfg_done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_code", res_code, 0);
    check("rst_rd_status", rd_status, 0);
    check("rst_turns", turns_left, T);
    check("rst_ships", ships_remaining, NS);
    check("rst_state", game_state, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_fire_ready", fire_ready, 0);
  endtask

  task automatic place(input int id, input int r, input int c, input int len, input bit v);
    bit imm_bad, ovl;
    int lat, n;
    imm_bad = (len == 0) || (len > ML) || (id >= NS) || ((id < NS) ? m_loaded[id] : 1'b1) ||
              (r >= R) || (c >= C) || (v ? (r + len - 1 >= R) : (c + len - 1 >= C));
    ovl = 0;
    if (!imm_bad) for (int k = 0; k < len; k++) if (m_occ[v ? r + k : r][v ? c : c + k]) ovl = 1;
    n = 0;
    while (!cfg_ready && n < 50) begin tick(); n++; end
    check("cfg_ready", cfg_ready, 1);
    cfg_valid = 1; cfg_id = 3'(id); cfg_row = 4'(r); cfg_col = 4'(c); cfg_len = 3'(len); cfg_vert = v;
    tick();
    cfg_valid = 0;
    lat = 1;
    while (!cfg_done && lat < 64) begin tick(); lat++; end
    check("cfg_done_seen", cfg_done, 1);
    check("cfg_err", cfg_err, (imm_bad || ovl) ? 1 : 0);
    if (imm_bad) check("cfg_rej_lat", lat, 1);
    else if (!ovl) begin
      check("cfg_lat", lat, 2 * len + 1);
      for (int k = 0; k < len; k++) begin
        m_occ[v ? r + k : r][v ? c : c + k] = 1;
        m_id[v ? r + k : r][v ? c : c + k] = id;
      end
      s_row[id] = r; s_col[id] = c; s_len[id] = len; s_vert[id] = v; m_loaded[id] = 1;
    end
  endtask

  task automatic fire(input int r, input int c);
    int exp_code, exp_lat, lat, n, id;
    bit rdy_seen;
    exp_lat = 1;
    if (r >= R || c >= C) exp_code = 4;
    else if (m_st[r][c] != 0) exp_code = 3;
    else if (!m_occ[r][c]) begin
      m_st[r][c] = 1; m_turns--; exp_code = 0;
      if (m_turns == 0) m_gs = 3;
    end else begin
      id = m_id[r][c];
      m_st[r][c] = 2; s_hits[id]++;
      if (s_hits[id] == s_len[id]) begin
        for (int k = 0; k < s_len[id]; k++)
          m_st[s_vert[id] ? s_row[id] + k : s_row[id]][s_vert[id] ? s_col[id] : s_col[id] + k] = 3;
        m_ships--; exp_code = 2; exp_lat = s_len[id] + 1;
        if (m_ships == 0) m_gs = 2;
      end else exp_code = 1;
    end
    n = 0;
    while (!fire_ready && n < 50) begin tick(); n++; end
    check("fire_ready", fire_ready, 1);
    fire_valid = 1; fire_row = 4'(r); fire_col = 4'(c);
    tick();
    fire_valid = 0;
    lat = 1; rdy_seen = 0;
    while (!res_valid && lat < 40) begin
      if (fire_ready) rdy_seen = 1;
      tick(); lat++;
    end
    check("res_valid_seen", res_valid, 1);
    check("res_code", res_code, exp_code);
    check("res_lat", lat, exp_lat);
    check("turns_left", turns_left, m_turns);
    check("ships_remaining", ships_remaining, m_ships);
    check("game_state", game_state, m_gs);
    if (exp_lat > 1) check("sink_fire_ready", rdy_seen, 0);
  endtask

  task automatic check_cell(input int r, input int c);
    rd_row = 4'(r); rd_col = 4'(c);
    tick();
    check("rd_status", rd_status, (r < R && c < C) ? m_st[r][c] : 0);
  endtask

  task automatic find_free(output int fr, output int fc);
    bit found;
    found = 0; fr = 0; fc = 0;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++)
      if (!found && !m_occ[r][c] && m_st[r][c] == 0) begin fr = r; fc = c; found = 1; end
  endtask

  task automatic do_restart();
    restart = 1;
    tick();
    restart = 0;
    model_clear_shots();
    check("rs_state", game_state, 1);
    check("rs_turns", turns_left, T);
    check("rs_ships", ships_remaining, NS);
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
    if (m_gs == 0) begin
      bit all;
      all = 1;
      for (int s = 0; s < NS; s++) if (!m_loaded[s]) all = 0;
      if (all) model_clear_shots();
    end
    check("start_state", game_state, m_gs);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr, fc, id, cand, b;
    model_reset();
    tick(); tick();
    reset = 0;
    check_reset_outputs();

    // Directed layout with one overlap reject and one bounds reject.
    place(0, 1, 1, 6, 0);
    place(1, 0, 3, 4, 1);
    place(1, 9, 9, 3, 0);
    place(1, 3, 3, 5, 1);
    place(2, 5, 5, 5, 0);
    place(3, 0, 8, 3, 1);
    do_start();
    place(4, 7, 0, 3, 1);
    do_start();

    fire(0, 0);
    check_cell(0, 0);
    fire(0, 0);
    fire(12, 0);
    fire(0, 3);
    fire(0, 8);
    fire(1, 8);
    fire(2, 8);
    for (int k = 0; k < 3; k++) check_cell(k, 8);
    while (m_gs == 1) begin find_free(fr, fc); fire(fr, fc); end
    check("lose_fire_ready", fire_ready, 0);
    tick();
    check("lose_held", game_state, 3);

    do_restart();
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) check_cell(r, c);
    check_cell(12, 3);
    fire(1, 1);

    // Sink the whole fleet.
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < s_len[s]; k++) begin
        fr = s_vert[s] ? s_row[s] + k : s_row[s];
        fc = s_vert[s] ? s_col[s] : s_col[s] + k;
        if (m_st[fr][fc] == 0) fire(fr, fc);
      end
    check("win_state", game_state, 2);
    check("win_fire_ready", fire_ready, 0);

    // Reset while a sink sweep is in flight.
    do_restart();
    fire(0, 8);
    fire(1, 8);
    fire_valid = 1; fire_row = 4'd2; fire_col = 4'd8;
    tick();
    fire_valid = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    model_reset();
    check_reset_outputs();

    // Random layout attempts, then fill any gaps with single-cell ships.
    repeat (60) begin
      id = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        cand = -1; b = int'($urandom_range(0, NS - 1));
        for (int k = 0; k < NS; k++) if (cand < 0 && !m_loaded[(b + k) % NS]) cand = (b + k) % NS;
        if (cand >= 0) id = cand;
      end
      place(id, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    for (int s = 0; s < NS; s++) if (!m_loaded[s]) begin find_free(fr, fc); place(s, fr, fc, 1, 0); end
    do_start();

    // Random games against the model.
    for (int g = 0; g < 4; g++) begin
      for (int n = 0; n < 120 && m_gs == 1; n++) begin
        if ($urandom_range(0, 7) == 0) begin
          fr = int'($urandom_range(0, 15)); fc = int'($urandom_range(0, 15));
        end else begin
          fr = int'($urandom_range(0, R - 1)); fc = int'($urandom_range(0, C - 1));
        end
        fire(fr, fc);
        if ($urandom_range(0, 3) == 0) check_cell(fr, fc);
      end
      do_restart();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
